// File: rtl/srrc_rx_fold_ctrl.sv
// Sequencer for a folded 17-tap symmetric SRRC receive filter: one pre-adder,
// one 18x18 multiplier and one accumulator time-shared over 9 clocks per sample.
module srrc_rx_fold_ctrl #(
  parameter int DATA_W = 18,
  parameter int NHALF  = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_en,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [DATA_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun,
  output logic                     wr_rej
);

  localparam int NTAPS = 2*NHALF - 1;
  localparam logic [3:0] LAST_K = 4'(NHALF - 1);
  localparam logic [4:0] LAST_X = 5'(NTAPS - 1);

  localparam logic signed [DATA_W-1:0] BDEF [NHALF] = '{
    18'sd3259, -18'sd3378, -18'sd10461, -18'sd12207, -18'sd3946,
    18'sd14611, 18'sd38196, 18'sd57937, 18'sd65624
  };

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_next;

  logic signed [DATA_W-1:0]   x [NTAPS];
  logic signed [DATA_W-1:0]   b [NHALF];
  logic signed [DATA_W-1:0]   acc;
  logic [3:0]                 cnt;

  logic                       accept;
  logic                       coef_ok;
  logic [4:0]                 hi_idx;
  logic signed [DATA_W-1:0]   pre;
  logic signed [2*DATA_W-1:0] pre_w, coef_w, prod;
  logic signed [DATA_W-1:0]   term;
  logic signed [DATA_W-1:0]   acc_sum;

  assign accept  = sample_en && (state != MAC);
  assign coef_ok = coef_we && (coef_addr <= LAST_K);

  // Folded tap k pairs x[k] with x[16-k]; the centre tap has no partner.
  always_comb begin
    hi_idx  = LAST_X - {1'b0, cnt};
    pre     = (cnt < LAST_K) ? x[{1'b0, cnt}] + x[hi_idx] : x[NHALF-1];
    pre_w   = (2*DATA_W)'(pre);
    coef_w  = (2*DATA_W)'(b[cnt]);
    prod    = pre_w * coef_w;
    term    = prod[2*DATA_W-2:DATA_W-1];
    acc_sum = acc + term;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MAC;
      MAC:     if (cnt == LAST_K) state_next = DONE;
      DONE:    state_next = accept ? MAC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == MAC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) x[i] <= '0;
      for (int unsigned i = 0; i < NHALF; i++) b[i] <= BDEF[i];
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      wr_rej    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      wr_rej    <= 1'b0;
      // A write accepted on the same edge as a sample is seen by that sample's MAC,
      // since the first tap is computed one edge later.
      if (coef_ok) begin
        if (state == MAC) wr_rej <= 1'b1;
        else              b[coef_addr] <= coef_data;
      end
      if (sample_en && state == MAC) overrun <= 1'b1;
      if (accept) begin
        for (int unsigned i = 1; i < NTAPS; i++) x[i] <= x[i-1];
        x[0] <= in;
        cnt  <= '0;
        acc  <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        cnt <= cnt + 4'd1;
        if (cnt == LAST_K) begin
          out       <= acc_sum;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_srrc_rx_fold_ctrl.sv
// Scoreboard bench for srrc_rx_fold_ctrl: expected outputs are queued at sample
// acceptance and popped when out_valid pulses.
module tb_srrc_rx_fold_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_en = 1'b0;
  logic signed [17:0] in = '0;
  logic               coef_we = 1'b0;
  logic [3:0]         coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic signed [17:0] out;
  logic               out_valid, busy, overrun, wr_rej;

  srrc_rx_fold_ctrl #(.DATA_W(18), .NHALF(9)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .in(in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun),
    .wr_rej(wr_rej)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int cyc;} exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -100;
  bit m_ovr = 1'b0;
  int mx [17];
  int mb [9];
  int bdef [9] = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624};
  int imp  [17] = '{3258, -3378, -10461, -12207, -3946, 14610, 38195, 57936, 65623,
                    57936, 38195, 14610, -3946, -12207, -10461, -3378, 3258};

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic longint wrap18(input longint v);
    longint r;
    r = v & 64'h3FFFF;
    if (r >= 131072) r = r - 262144;
    return r;
  endfunction

  function automatic int model_out();
    longint acc, p, m;
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      p = (k < 8) ? wrap18(longint'(mx[k]) + longint'(mx[16-k])) : longint'(mx[8]);
      m = p * longint'(mb[k]);
      acc = acc + (m >>> 17);
    end
    return int'(wrap18(acc));
  endfunction

  function automatic bit model_busy_at_edge(input int c);
    return (c > last_acc) && (c <= last_acc + 9);
  endfunction

  // One clock: drive inputs, let the edge happen, update the model, check flags.
  task automatic step(input bit se, input int v, input bit we, input int a, input int d,
                      input bit use_k, input int kval);
    bit mbusy, rej;
    exp_t e;
    sample_en = se; in = 18'(v); coef_we = we; coef_addr = 4'(a); coef_data = 18'(d);
    @(posedge clk);
    cyc++;
    mbusy = model_busy_at_edge(cyc);
    rej = we && (a <= 8) && mbusy;
    if (we && a <= 8 && !mbusy) mb[a] = d;
    if (se && mbusy) m_ovr = 1'b1;
    if (se && !mbusy) begin
      for (int i = 16; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = int'(wrap18(longint'(v)));
      last_acc = cyc;
      e.val = use_k ? kval : model_out();
      e.cyc = cyc + 9;
      q.push_back(e);
    end
    #1;
    sample_en = 1'b0; coef_we = 1'b0;
    check("wr_rej", wr_rej, rej);
    check("busy", busy, (cyc >= last_acc) && (cyc < last_acc + 9));
    check("overrun", overrun, m_ovr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic send(input int v, input int gap, input bit use_k, input int kval);
    step(1'b1, v, 1'b0, 0, 0, use_k, kval);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    q.delete();
    last_acc = -100;
    m_ovr = 1'b0;
    for (int i = 0; i < 17; i++) mx[i] = 0;
    for (int i = 0; i < 9; i++) mb[i] = bdef[i];
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_rej", wr_rej, 0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      check("out_x", $isunknown(out), 0);
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out", out, e.val);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // T1 impulse
    for (int i = 0; i < 17; i++) send(i == 0 ? 131071 : 0, 10, 1'b1, imp[i]);

    // T2 DC with pre-add wrap
    do_reset();
    for (int i = 0; i < 17; i++) send(131071, 10, 1'b0, 0);

    // T3 strobes 5 apart: every second one dropped
    do_reset();
    for (int i = 0; i < 8; i++) send(1000 * (i + 1) - 3000, 5, 1'b0, 0);
    idle(10);
    check("t3_overrun", overrun, 1);

    // T4 back-to-back random
    do_reset();
    for (int i = 0; i < 1000; i++) send(int'($signed(18'($urandom))), 10, 1'b0, 0);
    idle(10);
    check("t4_overrun", overrun, 0);

    // T5 coefficient writes: b[8]=0 accepted, b[0]=0 during MAC refused
    do_reset();
    step(1'b0, 0, 1'b1, 8, 0, 1'b0, 0);
    idle(1);
    step(1'b1, 131071, 1'b0, 0, 0, 1'b1, imp[0]);
    idle(2);
    step(1'b0, 0, 1'b1, 0, 0, 1'b0, 0);
    check("t5_rej", wr_rej, 1);
    idle(6);
    step(1'b0, 0, 1'b1, 12, 5, 1'b0, 0);
    check("t5_hiaddr_rej", wr_rej, 0);
    for (int i = 1; i < 17; i++) send(0, 10, 1'b1, i == 8 ? 0 : imp[i]);

    // T6 reset at E4 then a fresh impulse
    idle(2);
    step(1'b1, 131071, 1'b0, 0, 0, 1'b0, 0);
    idle(3);
    do_reset();
    send(131071, 10, 1'b1, 3258);
    idle(5);

    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
